// File: rtl/alu_pipe.sv
// alu_pipe: registered ARM data-processing ALU with an iterative shift-add
// multiplier, valid/ready handshakes on both sides and the NZCV flag register.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             set_flags,
  input  logic             shifter_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             write_result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_EOR = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_RSB = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SBC = 5'b00110;
  localparam logic [4:0] OP_RSC = 5'b00111;
  localparam logic [4:0] OP_TST = 5'b01000;
  localparam logic [4:0] OP_TEQ = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_CMN = 5'b01011;
  localparam logic [4:0] OP_ORR = 5'b01100;
  localparam logic [4:0] OP_MOV = 5'b01101;
  localparam logic [4:0] OP_BIC = 5'b01110;
  localparam logic [4:0] OP_MVN = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_MLA = 5'b10001;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic             mul_sf;

  logic [WIDTH-1:0] opx;
  logic [WIDTH-1:0] opy;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             is_arith;
  logic             is_mul;
  logic             is_nop;
  logic             alu_wr;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_nzcv;
  logic [WIDTH-1:0] prod_next;
  logic [WIDTH-1:0] mplier_next;
  logic             accept;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign busy     = (state == ST_MUL);
  assign accept   = in_valid && in_ready;

  // Steer operands into one WIDTH+1 adder (subtracts invert the subtrahend) and form the single-cycle result and flags.
  always_comb begin
    opx      = a;
    opy      = b;
    cin      = 1'b0;
    is_arith = 1'b0;
    is_mul   = 1'b0;
    is_nop   = 1'b0;
    alu_wr   = 1'b1;
    alu_res  = '0;
    case (op)
      OP_AND, OP_TST: alu_res = a & b;
      OP_EOR, OP_TEQ: alu_res = a ^ b;
      OP_ORR:         alu_res = a | b;
      OP_MOV:         alu_res = b;
      OP_BIC:         alu_res = a & ~b;
      OP_MVN:         alu_res = ~b;
      OP_SUB, OP_CMP: begin opy = ~b; cin = 1'b1; is_arith = 1'b1; end
      OP_RSB:         begin opx = b; opy = ~a; cin = 1'b1; is_arith = 1'b1; end
      OP_ADD, OP_CMN: is_arith = 1'b1;
      OP_ADC:         begin cin = flags[1]; is_arith = 1'b1; end
      OP_SBC:         begin opy = ~b; cin = flags[1]; is_arith = 1'b1; end
      OP_RSC:         begin opx = b; opy = ~a; cin = flags[1]; is_arith = 1'b1; end
      OP_MUL, OP_MLA: is_mul = 1'b1;
      default:        begin is_nop = 1'b1; alu_wr = 1'b0; end
    endcase
    if (op == OP_TST || op == OP_TEQ || op == OP_CMP || op == OP_CMN) alu_wr = 1'b0;
    sum = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
    ovf = (opx[WIDTH-1] == opy[WIDTH-1]) && (sum[WIDTH-1] != opx[WIDTH-1]);
    if (is_arith) alu_res = sum[WIDTH-1:0];
    alu_nzcv = {alu_res[WIDTH-1], (alu_res == '0),
                is_arith ? sum[WIDTH] : shifter_carry,
                is_arith ? ovf : flags[0]};
  end

  // One shift-add multiply step; the engine stops once no multiplier bits remain.
  always_comb begin
    prod_next   = mplier[0] ? prod + mcand : prod;
    mplier_next = mplier >> 1;
  end

  // Control FSM, output register and flag register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      result       <= '0;
      write_result <= 1'b0;
      flags        <= 4'b0000;
      mcand        <= '0;
      mplier       <= '0;
      prod         <= '0;
      mul_sf       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= a;
              mplier <= b;
              prod   <= (op == OP_MLA) ? acc : '0;
              mul_sf <= set_flags;
              state  <= ST_MUL;
            end else begin
              result       <= alu_res;
              write_result <= alu_wr;
              out_valid    <= 1'b1;
              if (set_flags && !is_nop) flags <= alu_nzcv;
            end
          end
        end
        ST_MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          if (mplier_next == '0) begin
            state        <= ST_IDLE;
            result       <= prod_next;
            write_result <= 1'b1;
            out_valid    <= 1'b1;
            if (mul_sf) flags <= {prod_next[WIDTH-1], (prod_next == '0), flags[1:0]};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

  localparam logic [4:0] ADD = 5'd4;
  localparam logic [4:0] ADC = 5'd5;
  localparam logic [4:0] SUB = 5'd2;
  localparam logic [4:0] CMP = 5'd10;
  localparam logic [4:0] MVN = 5'd15;
  localparam logic [4:0] MUL = 5'd16;
  localparam logic [4:0] MLA = 5'd17;

  logic        clk;
  logic        nReset;
  logic        in_valid, in_ready, set_flags, shifter_carry;
  logic [4:0]  op;
  logic [31:0] a, b, acc, result;
  logic        out_valid, out_ready, write_result, busy;
  logic [3:0]  flags;

  logic        in_valid_8, in_ready_8, set_flags_8, shifter_carry_8;
  logic [4:0]  op_8;
  logic [7:0]  a_8, b_8, acc_8, result_8;
  logic        out_valid_8, out_ready_8, write_result_8, busy_8;
  logic [3:0]  flags_8;

  int          checks;
  int          errors;
  logic [3:0]  mflags;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc(acc), .set_flags(set_flags), .shifter_carry(shifter_carry),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .write_result(write_result), .flags(flags), .busy(busy)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .nReset(nReset), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
    .a(a_8), .b(b_8), .acc(acc_8), .set_flags(set_flags_8), .shifter_carry(shifter_carry_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .result(result_8),
    .write_result(write_result_8), .flags(flags_8), .busy(busy_8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: ARM data-processing semantics with plain integer arithmetic.
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] ac, input logic sf, input logic sc,
                                input logic [3:0] fl, output logic [31:0] r, output logic wr,
                                output logic [3:0] nf, output int lat);
    longint ua, ub, sa, sb, s, ss;
    logic [31:0] px, py;
    logic c, v, cb;
    int mode, t;
    c = fl[1]; v = fl[0]; r = '0; wr = 1'b1; lat = 0;
    px = x; py = y; cb = 1'b0; mode = 0; s = 0; ss = 0;
    case (o)
      5'd0, 5'd8:  r = x & y;
      5'd1, 5'd9:  r = x ^ y;
      5'd12:       r = x | y;
      5'd13:       r = y;
      5'd14:       r = x & ~y;
      5'd15:       r = ~y;
      5'd2, 5'd10: mode = 2;
      5'd3:        begin mode = 2; px = y; py = x; end
      5'd4, 5'd11: mode = 1;
      5'd5:        begin mode = 1; cb = fl[1]; end
      5'd6:        begin mode = 2; cb = !fl[1]; end
      5'd7:        begin mode = 2; px = y; py = x; cb = !fl[1]; end
      5'd16:       begin mode = 3; r = x * y; end
      5'd17:       begin mode = 3; r = x * y + ac; end
      default:     mode = 4;
    endcase
    ua = px; ub = py; sa = $signed(px); sb = $signed(py);
    if (mode == 1) begin s = ua + ub + cb; ss = sa + sb + cb; end
    if (mode == 2) begin s = ua - ub - cb; ss = sa - sb - cb; end
    if (mode == 1 || mode == 2) begin
      r = s[31:0];
      c = (mode == 1) ? (s > 64'sh0_FFFF_FFFF) : (s >= 0);
      t = r;
      v = (ss != longint'(t));
    end
    if (mode == 0) c = sc;
    if (mode == 3) begin
      lat = 1;
      for (int k = 0; k < 32; k++) if (y[k]) lat = k + 1;
    end
    if ((o >= 5'd8 && o <= 5'd11) || mode == 4) wr = 1'b0;
    nf = (sf && mode != 4) ? {r[31], (r == 32'd0), c, v} : fl;
  endfunction

  // Present one op, wait for acceptance and completion, compare everything against the model.
  task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ac, input logic sf, input logic sc);
    logic [31:0] er;
    logic        ew;
    logic [3:0]  ef;
    int          el, lat, bcnt, w;
    model(o, x, y, ac, sf, sc, mflags, er, ew, ef, el);
    op = o; a = x; b = y; acc = ac; set_flags = sf; shifter_carry = sc; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    check("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 100) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, el);
    check("busy_cycles", bcnt, (o == MUL || o == MLA) ? el : 0);
    if (!(o >= 5'd8 && o <= 5'd11)) check("result", result, er);
    check("write_result", {31'd0, write_result}, {31'd0, ew});
    check("flags", {28'd0, flags}, {28'd0, ef});
    mflags = ef;
  endtask

  initial begin
    checks = 0; errors = 0; mflags = 4'b0000;
    nReset = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0; acc = '0; set_flags = 1'b0; shifter_carry = 1'b0;
    out_ready = 1'b1;
    in_valid_8 = 1'b0; op_8 = '0; a_8 = '0; b_8 = '0; acc_8 = '0; set_flags_8 = 1'b0;
    shifter_carry_8 = 1'b0; out_ready_8 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    nReset = 1'b1;
    @(posedge clk); #1;

    // WIDTH=8 compare and move-not
    op_8 = CMP; a_8 = 8'h10; b_8 = 8'h20; set_flags_8 = 1'b1; in_valid_8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready", {31'd0, in_ready_8}, 32'd1);
    @(posedge clk); #1;
    check("w8_cmp_wr", {31'd0, write_result_8}, 32'd0);
    check("w8_cmp_nzcv", {28'd0, flags_8}, {28'd0, 4'b1000});
    op_8 = MVN; a_8 = 8'h00; b_8 = 8'h0F; shifter_carry_8 = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    check("w8_mvn_result", {24'd0, result_8}, 32'h0000_00F0);
    check("w8_mvn_c", {31'd0, flags_8[1]}, 32'd1);
    check("w8_mvn_wr", {31'd0, write_result_8}, 32'd1);

    // Signed overflow on ADD, then equal SUB
    do_op(ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_nzcv", {28'd0, flags}, {28'd0, 4'b1001});
    do_op(SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    check("sub_eq_nzcv", {28'd0, flags}, {28'd0, 4'b0110});

    // Back-to-back carry chain, no bubble
    op = ADD; a = 32'hFFFF_FFFF; b = 32'd1; set_flags = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("chain_ready0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("chain_add_result", result, 32'd0);
    check("chain_add_nzcv", {28'd0, flags}, {28'd0, 4'b0110});
    op = ADC; a = 32'd0; b = 32'd0;
    @(negedge clk);
    check("chain_ready1", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("chain_adc_valid", {31'd0, out_valid}, 32'd1);
    check("chain_adc_result", result, 32'd1);
    check("chain_adc_nzcv", {28'd0, flags}, {28'd0, 4'b0000});
    mflags = 4'b0000;

    // Multiply-accumulate and zero multiplier
    do_op(MLA, 32'd3, 32'h10, 32'd7, 1'b0, 1'b0);
    check("mla_result", result, 32'h37);
    do_op(SUB, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 1'b0);
    check("sub_cv_nzcv", {28'd0, flags}, {28'd0, 4'b0011});
    do_op(MUL, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    check("mul0_nzcv", {28'd0, flags}, {28'd0, 4'b0111});

    // Backpressure: result held, nothing accepted, then release
    do_op(ADD, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    op = SUB; a = 32'd100; b = 32'd1; set_flags = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result", result, 32'd30);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_result", result, 32'd99);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  o;
      logic [31:0] x, y, z;
      o = 5'($urandom_range(0, 20));
      if (i % 15 == 7) o = 5'd31;
      x = $urandom; y = $urandom; z = $urandom;
      case ($urandom_range(0, 3))
        0:       x = 32'hFFFF_FFFF;
        1:       y = x;
        default: ;
      endcase
      if (o == MUL || o == MLA) y = y >> $urandom_range(0, 31);
      do_op(o, x, y, z, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a long multiply
    op = MUL; a = 32'd3; b = 32'h8000_0000; acc = '0; set_flags = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midmul_busy", {31'd0, busy}, 32'd1);
    nReset = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {28'd0, flags}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    nReset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_result", {31'd0, out_valid}, 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational ARM7 ALU. It executes the full 16-entry ARM data-processing opcode set plus MUL/MLA at any WIDTH, and owns the architectural NZCV flag register. It uses a valid/ready handshake on input and output. Logical and arithmetic ops complete in one cycle; multiplies run an iterative shift-add engine with ARM7-style early termination. It sits between the register-read/barrel-shifter stage and writeback in the execute pipeline.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (legal range ≥ 8).

Ports:
- clk  in  1  system clock, all state on rising edge
- nReset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; transfer on in_valid && in_ready
- op  in  5  opcode: 00000 AND, 00001 EOR, 00010 SUB, 00011 RSB, 00100 ADD, 00101 ADC, 00110 SBC, 00111 RSC, 01000 TST, 01001 TEQ, 01010 CMP, 01011 CMN, 01100 ORR, 01101 MOV, 01110 BIC, 01111 MVN, 10000 MUL, 10001 MLA, others NOP
- a  in  WIDTH  operand A (Rn; multiplicand Rm for MUL/MLA)
- b  in  WIDTH  operand B (shifter output; multiplier Rs for MUL/MLA)
- acc  in  WIDTH  MLA addend (Rn)
- set_flags  in  1  S bit: update NZCV at completion
- shifter_carry  in  1  barrel-shifter carry-out, used as C for logical ops
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result; transfer on out_valid && out_ready
- result  out  WIDTH  registered result
- write_result  out  1  registered; 0 for TST/TEQ/CMP/CMN/NOP
- flags  out  4  registered NZCV, bit 3 = N … bit 0 = V
- busy  out  1  multiply engine active

## Operation
- States: IDLE, MUL. in_ready = (state==IDLE) && (!out_valid || out_ready). Full throughput for back-to-back single-cycle ops.
- Single-cycle op accepted at edge E: result, write_result and (if set_flags) flags load at E; out_valid=1 after E.
- Arithmetic is computed at WIDTH+1 bits; Cin = flags.C for ADC/SBC/RSC, 1 for SUB/RSB/CMP, 0 for ADD/CMN.
- Arithmetic C = carry-out. For subtracts, C = NOT borrow (A ≥ B for SUB).
- Arithmetic V = signed overflow of the WIDTH-bit result.
- Logical ops: C = shifter_carry; V unchanged.
- N = result[WIDTH-1]. Z = (result == 0). For compare/test ops, flags come from the discarded result.
- ADC/SBC/RSC read the flag register value current at acceptance. A back-to-back carry chain therefore sees the previous op's C.
- MUL/MLA accepted at edge E:
  - Load mcand=a, mplier=b, prod=(MLA ? acc : 0); enter MUL.
  - Each MUL edge: if mplier[0], prod += mcand. Then mcand <<= 1 and mplier >>= 1.
  - Early termination: finish at the edge where the shifted mplier becomes 0, or after WIDTH iterations. At that edge result = prod[WIDTH-1:0], out_valid=1, state→IDLE.
  - Multiply flags: N and Z updated, C and V unchanged.
- NOP opcodes: accepted, result=0, write_result=0, flags unchanged.
- The output register holds result, write_result and out_valid stable until out_ready. out_valid drops on a transfer unless a new completion loads at the same edge.

## Timing
- Reset (async, nReset=0): state IDLE, out_valid 0, result 0, write_result 0, flags 0000, busy 0, multiply registers 0. in_ready=1 after reset once out_valid=0.
- Reset asserted mid-multiply aborts the multiply. No result is produced.
- Latency:
  - Single-cycle ops: 1 edge.
  - MUL/MLA: 1 edge to accept, then k iterations, where k = index of highest set bit of b + 1 (k = 1 if b = 0). out_valid rises k edges after acceptance.
- busy = (state==MUL).
- in_ready=0 throughout MUL.
- Stall: out_valid=1 && out_ready=0 forces in_ready=0, and nothing is accepted.
- Simultaneous out transfer and in acceptance: the old result leaves and the new one loads at the same edge, so out_valid stays 1.
- Flags change only at a completion edge with set_flags=1 (latched at acceptance).

## Test plan
- Reset: drive nReset=0 mid-stream → result=0, flags=0000, out_valid=0, in_ready=1.
- WIDTH=32, ADD S:
  - a=0x7FFFFFFF, b=1 → result 0x80000000, NZCV=1001, one cycle after acceptance.
  - Then SUB S a=5, b=5 → result 0, NZCV=0110.
- Carry chain: ADD S 0xFFFFFFFF+1 (C=1), then immediately ADC a=0, b=0 → result 1. Zero bubbles, out_ready held 1.
- MLA a=3, b=0x10, acc=7 → result 0x37, busy for 5 cycles. MUL b=0 → completes 1 cycle after acceptance, Z=1, C/V unchanged.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → result stable, in_ready=0, no op lost. Release → next op accepted on the same edge.
- WIDTH=8: CMP S a=0x10, b=0x20 → write_result=0, NZCV=1000. MVN b=0x0F with shifter_carry=1 → result 0xF0, C=1.
